// File: rtl/quadrature_paddle_decoder_pkg.sv
// Shared encodings for the paddle quadrature decoder: Gray states, step
// directions, error saturation value and the transition classifier.
package quadrature_paddle_decoder_pkg;

    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_01 = 2'b01;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_10 = 2'b10;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [7:0] ERR_MAX = 8'd255;

    typedef enum logic [1:0] {
        MV_NONE,
        MV_UP,
        MV_DOWN,
        MV_ERR
    } move_e;

    function automatic logic [1:0] gray_next(input logic [1:0] s);
        case (s)
            QS_00:   return QS_01;
            QS_01:   return QS_11;
            QS_11:   return QS_10;
            default: return QS_00;
        endcase
    endfunction

    // {A,B} previous vs current: forward Gray step, reverse step, or both bits flipped.
    function automatic move_e classify(input logic [1:0] prev, input logic [1:0] cur);
        if (prev == cur)                 return MV_NONE;
        else if (cur == gray_next(prev)) return MV_UP;
        else if (prev == gray_next(cur)) return MV_DOWN;
        else                             return MV_ERR;
    endfunction

endpackage

// File: rtl/quadrature_paddle_decoder_filter.sv
// Per-channel input conditioning: 2-FF synchroniser followed by a stability
// counter that only accepts a level held for FILTER_LEN consecutive cycles.
module quad_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic changed
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic          chg_q, chg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            chg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            chg_q   <= chg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any return to the accepted level restarts the qualification count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        chg_d  = 1'b0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
                chg_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign dout    = filt_q;
    assign changed = chg_q;

endmodule

// File: rtl/quadrature_paddle_decoder.sv
// Paddle quadrature receiver: filtered A/B decode into +/-1 steps, clamped
// live position, saturating error count and a once-per-frame position latch.
module quadrature_paddle_decoder
    import quadrature_paddle_decoder_pkg::*;
#(
    parameter int POS_WIDTH  = 10,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 639,
    parameter int POS_INIT   = 320,
    parameter int FILTER_LEN = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 quad_a,
    input  logic                 quad_b,
    input  logic                 frame_tick,
    output logic [POS_WIDTH-1:0] position,
    output logic                 step_pulse,
    output logic                 step_dir,
    output logic [7:0]           err_count
);
    localparam int ARM_WAIT = FILTER_LEN + 2;
    localparam int AW       = $clog2(ARM_WAIT + 1);
    localparam logic [AW-1:0]        ARM_LAST = AW'(ARM_WAIT);
    localparam logic [POS_WIDTH-1:0] MIN_V    = POS_WIDTH'(POS_MIN);
    localparam logic [POS_WIDTH-1:0] MAX_V    = POS_WIDTH'(POS_MAX);
    localparam logic [POS_WIDTH-1:0] INIT_V   = POS_WIDTH'(POS_INIT);

    logic                 filt_a, filt_b, chg_a, chg_b;
    logic [1:0]           prev_q, prev_d;
    logic                 armed_q, armed_d;
    logic [AW-1:0]        arm_cnt_q, arm_cnt_d;
    logic [POS_WIDTH-1:0] live_q, live_d, pos_q, pos_d;
    logic                 pulse_q, pulse_d, dir_q, dir_d;
    logic [7:0]           err_q, err_d;
    move_e                mv;

    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk(clk), .reset(reset), .din(quad_a), .dout(filt_a), .changed(chg_a)
    );
    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk(clk), .reset(reset), .din(quad_b), .dout(filt_b), .changed(chg_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= QS_00;
            armed_q   <= 1'b0;
            arm_cnt_q <= '0;
            live_q    <= INIT_V;
            pos_q     <= INIT_V;
            pulse_q   <= 1'b0;
            dir_q     <= DIR_DOWN;
            err_q     <= '0;
        end else begin
            prev_q    <= prev_d;
            armed_q   <= armed_d;
            arm_cnt_q <= arm_cnt_d;
            live_q    <= live_d;
            pos_q     <= pos_d;
            pulse_q   <= pulse_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        prev_d    = {filt_a, filt_b};
        mv        = classify(prev_q, {filt_a, filt_b});
        armed_d   = armed_q;
        arm_cnt_d = arm_cnt_q;
        live_d    = live_q;
        pulse_d   = 1'b0;
        dir_d     = dir_q;
        err_d     = err_q;
        // The change that arms the decoder is itself swallowed, so pins idling at 11 never count.
        if (!armed_q) begin
            if (chg_a || chg_b || arm_cnt_q == ARM_LAST) armed_d = 1'b1;
            else                                         arm_cnt_d = arm_cnt_q + 1'b1;
        end else begin
            case (mv)
                MV_UP: begin
                    pulse_d = 1'b1;
                    dir_d   = DIR_UP;
                    if (live_q < MAX_V) live_d = live_q + 1'b1;
                end
                MV_DOWN: begin
                    pulse_d = 1'b1;
                    dir_d   = DIR_DOWN;
                    if (live_q > MIN_V) live_d = live_q - 1'b1;
                end
                MV_ERR: begin
                    if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                end
                default: ;
            endcase
        end
        pos_d = frame_tick ? live_d : pos_q;
    end

    assign position   = pos_q;
    assign step_pulse = pulse_q;
    assign step_dir   = dir_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_quadrature_paddle_decoder.sv
// Bench for quadrature_paddle_decoder: scoreboarded step pulses, table-driven
// forward sequence, clamp/error/arming/frame-latch/reset corner sequences.
module tb_quadrature_paddle_decoder;

    logic       clk = 1'b0;
    logic       reset, quad_a, quad_b, frame_tick;
    logic [9:0] position;
    logic       step_pulse, step_dir;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    quadrature_paddle_decoder #(
        .POS_WIDTH(10), .POS_MIN(0), .POS_MAX(639), .POS_INIT(320), .FILTER_LEN(4)
    ) dut (
        .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b),
        .frame_tick(frame_tick), .position(position), .step_pulse(step_pulse),
        .step_dir(step_dir), .err_count(err_count)
    );

    typedef struct {
        logic [1:0] ab;
        logic       step;
        logic       dir;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   last_pulse_cycle = -1;
    int   model_live = 320;
    int   model_err  = 0;
    logic [1:0] cur_ab = 2'b00;
    logic exp_q[$];
    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Every clock advance goes through here so pulses are scored as they appear.
    task automatic cyc();
        logic e;
        @(posedge clk);
        #1;
        cycle++;
        if (!reset && step_pulse) begin
            last_pulse_cycle = cycle;
            if (exp_q.size() == 0) begin
                chk("unexpected_step_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("step_dir", int'(step_dir), int'(e));
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    function automatic logic [1:0] fwd(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic drive(input logic [1:0] ab);
        cur_ab = ab;
        quad_a = ab[1];
        quad_b = ab[0];
    endtask

    task automatic expect_step(input logic dir);
        exp_q.push_back(dir);
        if (dir) model_live = (model_live < 639) ? model_live + 1 : 639;
        else     model_live = (model_live > 0)   ? model_live - 1 : 0;
    endtask

    task automatic step(input logic dir);
        drive(dir ? fwd(cur_ab) : rev(cur_ab));
        expect_step(dir);
        wait_cycles(8);
    endtask

    task automatic tick_frame();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{2'b11, 1'b1, 1'b1};
        tbl[1]  = '{2'b10, 1'b1, 1'b1};
        tbl[2]  = '{2'b00, 1'b1, 1'b1};
        tbl[3]  = '{2'b01, 1'b1, 1'b1};
        tbl[4]  = '{2'b11, 1'b1, 1'b1};
        tbl[5]  = '{2'b10, 1'b1, 1'b1};
        tbl[6]  = '{2'b00, 1'b1, 1'b1};
        tbl[7]  = '{2'b01, 1'b1, 1'b1};
        tbl[8]  = '{2'b11, 1'b1, 1'b1};
        tbl[9]  = '{2'b10, 1'b1, 1'b1};
        tbl[10] = '{2'b00, 1'b1, 1'b1};

        reset = 1'b1; frame_tick = 1'b0;
        drive(2'b00);
        wait_cycles(3);
        chk("reset_position", int'(position), 320);
        chk("reset_step_pulse", int'(step_pulse), 0);
        chk("reset_step_dir", int'(step_dir), 0);
        chk("reset_err_count", int'(err_count), 0);
        reset = 1'b0;
        wait_cycles(10);

        // Glitch shorter than the filter window.
        quad_a = 1'b1;
        wait_cycles(2);
        quad_a = 1'b0;
        wait_cycles(12);
        tick_frame();
        chk("glitch_err_count", int'(err_count), 0);
        chk("glitch_position", int'(position), 320);

        // First forward edge: latency from pin change to pulse.
        begin
            int c0;
            c0 = cycle;
            drive(2'b01);
            expect_step(1'b1);
            wait_cycles(8);
            chk("first_pulse_latency", last_pulse_cycle - c0, 7);
        end
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].ab);
            if (tbl[i].step) expect_step(tbl[i].dir);
            wait_cycles(8);
        end
        chk("fwd_pending_pulses", exp_q.size(), 0);
        chk("fwd_position_before_tick", int'(position), 320);
        tick_frame();
        chk("fwd_position", int'(position), 332);

        // Upper clamp.
        while (model_live < 638) step(1'b1);
        tick_frame();
        chk("pos_638", int'(position), 638);
        for (int i = 0; i < 3; i++) step(1'b1);
        chk("clamp_hi_pending_pulses", exp_q.size(), 0);
        tick_frame();
        chk("clamp_hi_position", int'(position), 639);

        // Lower clamp.
        while (model_live > 0) step(1'b0);
        for (int i = 0; i < 3; i++) step(1'b0);
        chk("clamp_lo_pending_pulses", exp_q.size(), 0);
        tick_frame();
        chk("clamp_lo_position", int'(position), 0);

        // Double transitions: counted, saturating, no steps.
        drive(cur_ab ^ 2'b11);
        model_err++;
        wait_cycles(8);
        chk("err_first", int'(err_count), model_err);
        for (int i = 1; i < 300; i++) begin
            drive(cur_ab ^ 2'b11);
            model_err = (model_err < 255) ? model_err + 1 : 255;
            wait_cycles(8);
        end
        chk("err_saturated", int'(err_count), model_err);
        tick_frame();
        chk("err_position_unchanged", int'(position), 0);

        // Step landing in the same cycle as frame_tick.
        drive(fwd(cur_ab));
        expect_step(1'b1);
        wait_cycles(6);
        tick_frame();
        chk("tick_coincident_position", int'(position), model_live);
        chk("tick_coincident_pending", exp_q.size(), 0);
        wait_cycles(4);

        // Reset in the middle of filtering an edge toward 11.
        drive(2'b11);
        wait_cycles(3);
        reset = 1'b1;
        cyc();
        chk("midreset_position", int'(position), 320);
        chk("midreset_step_pulse", int'(step_pulse), 0);
        chk("midreset_step_dir", int'(step_dir), 0);
        chk("midreset_err_count", int'(err_count), 0);
        model_live = 320;
        model_err  = 0;
        wait_cycles(3);
        reset = 1'b0;

        // Pins idle at 11 across reset: absorbed at arming.
        wait_cycles(30);
        chk("idle11_err_count", int'(err_count), 0);
        tick_frame();
        chk("idle11_position", int'(position), 320);
        step(1'b0);
        chk("idle11_rev_pending", exp_q.size(), 0);
        chk("idle11_rev_dir", int'(step_dir), 0);
        tick_frame();
        chk("idle11_rev_position", int'(position), 319);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
